handshake: RTL and testbench

HANDSHAKE -- requirements
Module: handshake

---
 rtl/handshake_pkg.sv | 18 +
 rtl/hs_timer.sv | 42 ++++
 rtl/handshake.sv | 75 +++++++
 tb/tb_handshake.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types and helpers for the start/done handshake FSM and its timeout timer.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    // Counter must be able to hold the value TIMEOUT itself; never narrower than 1 bit.
    function automatic int timer_width(input int timeout);
        if (timeout > 0) begin
            return $clog2(timeout + 1);
        end
        return 1;
    endfunction

endpackage

// File: rtl/hs_timer.sv
// Counts consecutive ACTIVE cycles; expired is combinational from the count, so the FSM acts on the
// edge that closes the TIMEOUT-th ACTIVE cycle. No backpressure; the count saturates at TIMEOUT.
module hs_timer
    import handshake_pkg::*;
#(
    parameter int TIMEOUT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of ACTIVE cycles already completed before the current one.
    assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/handshake.sv
// Moore start/done handshake: st is high exactly in ACTIVE, registered, one edge after rdy or dn is sampled.
// No backpressure; DONE always gives a one-cycle recovery gap; optional timeout returns ACTIVE to IDLE.
module handshake
    import handshake_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic dn,
    output logic st
);

    state_t state_q;
    state_t state_d;
    logic   st_q;
    logic   st_d;
    logic   tmr_clr;
    logic   tmr_en;
    logic   expired;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = rdy ? ACTIVE : IDLE;
            // dn wins over both rdy and a timeout landing on the same edge.
            ACTIVE: begin
                if (dn) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        st_d    = (state_d == ACTIVE);
        tmr_clr = (state_q != ACTIVE) && (state_d == ACTIVE);
        tmr_en  = (state_q == ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
        end
    end

    assign st = st_q;

    generate
        if (TIMEOUT > 0) begin : g_timer
            hs_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_timer (
                .clk     (clk),
                .rst     (rst),
                .clr     (tmr_clr),
                .en      (tmr_en),
                .expired (expired)
            );
        end else begin : g_no_timer
            logic unused_tmr;
            assign unused_tmr = tmr_clr | tmr_en;
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_handshake.sv
// Drives two handshake instances (TIMEOUT=0 and TIMEOUT=4) with shared stimulus and scoreboards st.
module tb_handshake;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic dn  = 1'b0;
    logic st0;
    logic st4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state 0=idle 1=active 2=done; act4 counts ACTIVE cycles incl. current.
    int ms0  = 0;
    int ms4  = 0;
    int act4 = 0;

    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    handshake #(.TIMEOUT(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .dn  (dn),
        .st  (st0)
    );

    handshake #(.TIMEOUT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .dn  (dn),
        .st  (st4)
    );

    task automatic chk(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: st=%b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms0  = 0;
        ms4  = 0;
        act4 = 0;
    endtask

    task automatic model_step(input logic r, input logic d);
        case (ms0)
            0:       if (r) ms0 = 1;
            1:       if (d) ms0 = 2;
            default: ms0 = 0;
        endcase
        case (ms4)
            0: begin
                if (r) begin
                    ms4  = 1;
                    act4 = 1;
                end
            end
            1: begin
                if (d) begin
                    ms4 = 2;
                end else if (act4 == 4) begin
                    ms4 = 0;
                end else begin
                    act4++;
                end
            end
            default: ms4 = 0;
        endcase
    endtask

    task automatic compare(input string tag);
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/t0"}, st0, e[1]);
            chk({tag, "/t4"}, st4, e[0]);
        end
    endtask

    // Called at posedge+1: apply inputs, predict, clock, then compare.
    task automatic step(input string tag, input logic r, input logic d);
        rdy = r;
        dn  = d;
        model_step(r, d);
        exp_q.push_back({(ms0 == 1), (ms4 == 1)});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        // Reset held across an edge with inputs quiet.
        @(posedge clk);
        #1;
        model_reset();
        exp_q.push_back(2'b00);
        compare("in_reset");
        rst = 1'b0;
        step("post_rst0", 1'b0, 1'b0);
        step("post_rst1", 1'b0, 1'b0);

        // Basic transfer.
        step("basic_start", 1'b1, 1'b0);
        step("basic_done", 1'b0, 1'b1);
        step("basic_idle", 1'b0, 1'b0);
        step("basic_quiet", 1'b0, 1'b0);

        // rdy+dn together in ACTIVE, then dn alone in IDLE.
        step("prio_start", 1'b1, 1'b0);
        step("prio_both", 1'b1, 1'b1);
        step("prio_gap", 1'b0, 1'b0);
        step("idle_dn", 1'b0, 1'b1);
        step("idle_quiet", 1'b0, 1'b0);

        // Continuous rdy, dn pulsed whenever the model says st is high.
        for (int i = 0; i < 12; i++) begin
            step("b2b", 1'b1, (ms0 == 1) ? 1'b1 : 1'b0);
        end
        step("b2b_end0", 1'b0, 1'b0);
        step("b2b_end1", 1'b0, 1'b0);
        step("b2b_end2", 1'b0, 1'b0);

        // Timeout: no dn, TIMEOUT=4 instance drops after 4 cycles, TIMEOUT=0 stays.
        step("to_start", 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step("to_wait", 1'b0, 1'b0);
        end
        step("to_dn", 1'b0, 1'b1);
        step("to_idle", 1'b0, 1'b0);

        // dn on the very edge the timeout is reached: DONE wins, so rdy right after is ignored.
        step("edge_start", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("edge_wait", 1'b0, 1'b0);
        end
        step("edge_dn", 1'b0, 1'b1);
        step("edge_rdy_in_done", 1'b1, 1'b0);
        step("edge_restart", 1'b1, 1'b0);
        step("edge_dn2", 1'b0, 1'b1);
        step("edge_idle", 1'b0, 1'b0);

        // Async reset between edges while st is high.
        step("ar_start", 1'b1, 1'b0);
        rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(2'b00);
        compare("ar_immediate");
        #2;
        rst = 1'b0;
        #1;
        step("ar_after", 1'b0, 1'b0);
        step("ar_restart", 1'b1, 1'b0);
        step("ar_done", 1'b0, 1'b1);
        step("ar_idle", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
